// File: rtl/serial_subtractor_16.sv
// Bit-serial subtractor: computes (in1 - in2 - bin) mod 2^WIDTH one bit per clock, LSB first,
// with a borrow-out flag and a one-cycle valid pulse on completion.
module serial_subtractor_16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic accept_c;
    logic last_c;
    logic bit_c;
    logic br_nxt_c;

    // New operands are taken whenever the unit is not mid-operation (IDLE or DONE).
    assign accept_c = start && (state_q != RUN);
    assign last_c   = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
    assign bit_c    = a_q[0] ^ b_q[0] ^ br_q;
    assign br_nxt_c = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_c) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the state register only
    always_comb begin
        busy  = 1'b0;
        valid = 1'b0;
        case (state_q)
            RUN:     busy  = 1'b1;
            DONE:    valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: load on accept, shift one bit per RUN cycle, publish on the last bit
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        br_d   = br_q;
        res_d  = res_q;
        cnt_d  = cnt_q;
        diff_d = diff_q;
        bout_d = bout_q;
        if (accept_c) begin
            a_d   = in1;
            b_d   = in2;
            br_d  = bin;
            res_d = '0;
            cnt_d = '0;
        end else if (state_q == RUN) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = br_nxt_c;
            res_d = {bit_c, res_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (last_c) begin
                diff_d = {bit_c, res_q[WIDTH-1:1]};
                bout_d = br_nxt_c;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            br_q   <= 1'b0;
            res_q  <= '0;
            cnt_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            br_q   <= br_d;
            res_q  <= res_d;
            cnt_q  <= cnt_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor_16.sv
// Directed and randomised checks for serial_subtractor_16 at WIDTH=16 and WIDTH=8.
module tb_serial_subtractor_16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] in1 = '0;
    logic [15:0] in2 = '0;
    logic        bin = 1'b0;
    logic        busy, valid, bout;
    logic [15:0] diff;

    logic        start8 = 1'b0;
    logic [7:0]  in1_8 = '0;
    logic [7:0]  in2_8 = '0;
    logic        bin8 = 1'b0;
    logic        busy8, valid8, bout8;
    logic [7:0]  diff8;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    serial_subtractor_16 #(.WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2), .bin(bin),
        .busy(busy), .valid(valid), .diff(diff), .bout(bout)
    );

    serial_subtractor_16 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .in1(in1_8), .in2(in2_8), .bin(bin8),
        .busy(busy8), .valid(valid8), .diff(diff8), .bout(bout8)
    );

    // Called at a falling edge; returns at the falling edge right after the accepting edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic bi);
        in1 = a; in2 = b; bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for valid; lat = -1 on timeout.
    task automatic wait_done(output int lat, output int busy_cycles,
                             output logic [15:0] d, output logic bo);
        lat = -1; busy_cycles = 0; d = '0; bo = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (valid) begin
                lat = n; d = diff; bo = bout;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        compared++; if (busy !== 1'b0)  begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
        compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", valid); end
        compared++; if (diff !== 16'h0) begin mismatched++; $display("FAIL reset_diff got %h want 0000", diff); end
        compared++; if (bout !== 1'b0)  begin mismatched++; $display("FAIL reset_bout got %b want 0", bout); end
    endtask

    task automatic test_basic();
        int lat, bc; logic [15:0] d; logic bo;
        rst = 1'b0;
        start_op(16'h1234, 16'h0034, 1'b0);
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL basic_busy_first got %b want 1", busy); end
        wait_done(lat, bc, d, bo);
        compared++; if (lat != 16) begin mismatched++; $display("FAIL basic_latency got %0d want 16", lat); end
        compared++; if (bc != 16)  begin mismatched++; $display("FAIL basic_busy_cycles got %0d want 16", bc); end
        compared++; if (d !== 16'h1200) begin mismatched++; $display("FAIL basic_diff got %h want 1200", d); end
        compared++; if (bo !== 1'b0) begin mismatched++; $display("FAIL basic_bout got %b want 0", bo); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy_done got %b want 0", busy); end
        @(negedge clk);
        compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL basic_valid_pulse got %b want 0", valid); end
        compared++; if (diff !== 16'h1200) begin mismatched++; $display("FAIL basic_diff_hold got %h want 1200", diff); end
    endtask

    task automatic test_borrow();
        int lat, bc; logic [15:0] d; logic bo;
        start_op(16'h0000, 16'h0001, 1'b0);
        wait_done(lat, bc, d, bo);
        compared++; if (d !== 16'hFFFF) begin mismatched++; $display("FAIL underflow_diff got %h want ffff", d); end
        compared++; if (bo !== 1'b1) begin mismatched++; $display("FAIL underflow_bout got %b want 1", bo); end
        @(negedge clk);
        start_op(16'h8000, 16'h7FFF, 1'b1);
        wait_done(lat, bc, d, bo);
        compared++; if (d !== 16'h0000) begin mismatched++; $display("FAIL exact_diff got %h want 0000", d); end
        compared++; if (bo !== 1'b0) begin mismatched++; $display("FAIL exact_bout got %b want 0", bo); end
        @(negedge clk);
    endtask

    task automatic test_operand_change();
        int lat, bc; logic [15:0] d; logic bo;
        start_op(16'hFFFF, 16'hFFFF, 1'b1);
        repeat (2) @(negedge clk);
        in1 = 16'hAAAA; in2 = 16'h5555; bin = 1'b0;
        wait_done(lat, bc, d, bo);
        compared++; if (d !== 16'hFFFF) begin mismatched++; $display("FAIL opchange_diff got %h want ffff", d); end
        compared++; if (bo !== 1'b1) begin mismatched++; $display("FAIL opchange_bout got %b want 1", bo); end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int pulses = 0, vn = -1; logic [15:0] dv = '0; logic bv = 1'b0;
        start_op(16'h5A5A, 16'h1111, 1'b1);
        for (int n = 0; n < 30; n++) begin
            start = (n == 3 || n == 10);
            if (n == 3 || n == 10) begin in1 = 16'h0000; in2 = 16'h0001; bin = 1'b0; end
            if (valid) begin pulses++; vn = n; dv = diff; bv = bout; end
            @(negedge clk);
        end
        start = 1'b0;
        compared++; if (pulses != 1) begin mismatched++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
        compared++; if (vn != 16) begin mismatched++; $display("FAIL ignore_latency got %0d want 16", vn); end
        compared++; if (dv !== 16'h4948) begin mismatched++; $display("FAIL ignore_diff got %h want 4948", dv); end
        compared++; if (bv !== 1'b0) begin mismatched++; $display("FAIL ignore_bout got %b want 0", bv); end
    endtask

    task automatic test_mid_reset();
        int lat, bc, pulses = 0; logic [15:0] d; logic bo;
        start_op(16'h0F0F, 16'h00F0, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compared++; if (busy !== 1'b0)  begin mismatched++; $display("FAIL midrst_busy got %b want 0", busy); end
        compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL midrst_valid got %b want 0", valid); end
        compared++; if (diff !== 16'h0) begin mismatched++; $display("FAIL midrst_diff got %h want 0000", diff); end
        compared++; if (bout !== 1'b0)  begin mismatched++; $display("FAIL midrst_bout got %b want 0", bout); end
        for (int n = 0; n < 20; n++) begin
            if (valid) pulses++;
            @(negedge clk);
        end
        compared++; if (pulses != 0) begin mismatched++; $display("FAIL midrst_no_valid got %0d want 0", pulses); end
        start_op(16'h0003, 16'h0005, 1'b1);
        wait_done(lat, bc, d, bo);
        compared++; if (lat != 16) begin mismatched++; $display("FAIL midrst_restart_lat got %0d want 16", lat); end
        compared++; if (d !== 16'hFFFD) begin mismatched++; $display("FAIL midrst_restart_diff got %h want fffd", d); end
        compared++; if (bo !== 1'b1) begin mismatched++; $display("FAIL midrst_restart_bout got %b want 1", bo); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int t[2] = '{-1, -1}; int pulses = 0;
        logic [15:0] dv[2] = '{16'h0, 16'h0}; logic bv[2] = '{1'b0, 1'b0};
        logic busy17 = 1'b0; logic [15:0] diff20 = '0;
        in1 = 16'h0100; in2 = 16'h0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 40; n++) begin
            if (n == 1) begin in1 = 16'h7000; in2 = 16'h8000; bin = 1'b1; end
            if (n == 17) begin start = 1'b0; busy17 = busy; end
            if (n == 20) diff20 = diff;
            if (valid) begin
                if (pulses < 2) begin t[pulses] = n; dv[pulses] = diff; bv[pulses] = bout; end
                pulses++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        compared++; if (pulses != 2) begin mismatched++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
        compared++; if (t[0] != 16) begin mismatched++; $display("FAIL b2b_first_lat got %0d want 16", t[0]); end
        compared++; if (t[1] - t[0] != 17) begin mismatched++; $display("FAIL b2b_spacing got %0d want 17", t[1] - t[0]); end
        compared++; if (busy17 !== 1'b1) begin mismatched++; $display("FAIL b2b_no_idle got %b want 1", busy17); end
        compared++; if (diff20 !== 16'h00FF) begin mismatched++; $display("FAIL b2b_hold_diff got %h want 00ff", diff20); end
        compared++; if (dv[0] !== 16'h00FF || bv[0] !== 1'b0) begin mismatched++; $display("FAIL b2b_res0 got %h/%b want 00ff/0", dv[0], bv[0]); end
        compared++; if (dv[1] !== 16'hEFFF || bv[1] !== 1'b1) begin mismatched++; $display("FAIL b2b_res1 got %h/%b want efff/1", dv[1], bv[1]); end
    endtask

    task automatic test_random();
        int lat, bc; logic [15:0] d, a, b; logic bo, bi; logic [16:0] exp;
        for (int i = 0; i < 300; i++) begin
            a = 16'($urandom); b = 16'($urandom); bi = 1'($urandom);
            if (i == 0) begin a = 16'h0000; b = 16'hFFFF; bi = 1'b1; end
            exp = {1'b0, a} - {1'b0, b} - 17'(bi);
            start_op(a, b, bi);
            wait_done(lat, bc, d, bo);
            compared++;
            if (lat != 16 || d !== exp[15:0] || bo !== exp[16]) begin
                mismatched++;
                $display("FAIL rand16 %h-%h-%b got %h/%b lat %0d want %h/%b lat 16", a, b, bi, d, bo, lat, exp[15:0], exp[16]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random_w8();
        int lat; logic [7:0] a, b, d; logic bo, bi; logic [8:0] exp;
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
            exp = {1'b0, a} - {1'b0, b} - 9'(bi);
            in1_8 = a; in2_8 = b; bin8 = bi; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            lat = -1; d = '0; bo = 1'b0;
            for (int n = 0; n < 20; n++) begin
                if (valid8) begin lat = n; d = diff8; bo = bout8; break; end
                @(negedge clk);
            end
            compared++;
            if (lat != 8 || d !== exp[7:0] || bo !== exp[8]) begin
                mismatched++;
                $display("FAIL rand8 %h-%h-%b got %h/%b lat %0d want %h/%b lat 8", a, b, bi, d, bo, lat, exp[7:0], exp[8]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_borrow();
        test_operand_change();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        test_random();
        test_random_w8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
